// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM encoding, frame widths and
// the bit-counter sizing used by spi_target.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_t;

  localparam int SPI_W_NARROW = 8;
  localparam int SPI_W_WIDE   = 32;
  localparam int SPI_CNT_W    = 5;

  // Index of the first (MSB) bit of a frame for the selected width.
  function automatic logic [SPI_CNT_W-1:0] spi_first_bit(input logic wide);
    return wide ? SPI_CNT_W'(SPI_W_WIDE - 1) : SPI_CNT_W'(SPI_W_NARROW - 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, with rise/fall
// detection on the synchronized value. Edges are only ever derived from the
// synchronized copy, never from the raw pin.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_p;
  logic              q_p1;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p <= {STAGES{RST_VAL}};
      q_p1   <= RST_VAL;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
      q_p1   <= sync_p[STAGES-1];
    end
  end

  assign q    = sync_p[STAGES-1];
  assign rise = q & ~q_p1;
  assign fall = ~q & q_p1;

endmodule

// File: rtl/spi_target.sv
// SPI responder, mode 0 (CPOL=0/CPHA=0), MSB first, 8- or 32-bit frames.
// SCLK, CS_n and MOSI are oversampled on sys_clk_in; a preloaded word is
// returned on MISO while the initiator's word is captured into rx_data.
// Optional build macro SPI_TARGET_ERR_CNT_EN adds err_clr / err_cnt, a
// saturating count of abort, overrun and underrun events.
module spi_target
  import spi_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] IDLE_FILL   = 32'hFFFF_FFFF
) (
  input  logic        sys_clk_in,
  input  logic        rst,
  input  logic        spi_clk_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_t,
  input  logic        spi_wide,
  input  logic [31:0] tx_data,
  input  logic        tx_load,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        busy,
  output logic        frame_abort,
  output logic        rx_overrun,
  output logic        tx_underrun
`ifdef SPI_TARGET_ERR_CNT_EN
  ,
  input  logic        err_clr,
  output logic [7:0]  err_cnt
`endif
);

  spi_state_t           state, state_nxt;

  logic                 sclk_s, sclk_rise, sclk_fall;
  logic                 cs_n_s, cs_rise, cs_fall;
  logic                 mosi_s, mosi_rise, mosi_fall;

  logic                 start, shift_in, complete, advance, abort, finish;

  logic                 wide_q;
  logic [SPI_CNT_W-1:0] bit_cnt;
  logic                 pending;
  logic [31:0]          tx_buf;
  logic [31:0]          tx_sh;
  logic [31:0]          rx_sh;

  logic                 load_have;
  logic [31:0]          fill_word;
  logic [31:0]          tx_init;
  logic [31:0]          rx_next;

  logic                 unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk  (sys_clk_in),
    .rst  (rst),
    .d    (spi_clk_i),
    .q    (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk  (sys_clk_in),
    .rst  (rst),
    .d    (spi_cs_n_i),
    .q    (cs_n_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk  (sys_clk_in),
    .rst  (rst),
    .d    (spi_mosi_i),
    .q    (mosi_s),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  // Only the edge strobes of SCLK/CS and the level of MOSI are consumed.
  assign unused_sync = &{1'b0, sclk_s, cs_n_s, mosi_rise, mosi_fall, rx_sh[31]};

  // A tx_load in the same cycle as the CS-fall detect wins over the buffer.
  assign load_have = tx_load | pending;
  assign fill_word = !load_have ? IDLE_FILL : (tx_load ? tx_data : tx_buf);
  assign tx_init   = spi_wide ? fill_word : {fill_word[7:0], 24'h0};
  assign rx_next   = {rx_sh[30:0], mosi_s};

  assign busy      = (state != IDLE);
  assign tx_ready  = ~pending;

  // FSM state register.
  always_ff @(posedge sys_clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and per-cycle frame strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_in  = 1'b0;
    complete  = 1'b0;
    advance   = 1'b0;
    abort     = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          if (sclk_rise) begin
            shift_in = 1'b1;
            if (bit_cnt == '0) begin
              complete  = 1'b1;
              state_nxt = DONE;
            end
          end
          if (sclk_fall) advance = 1'b1;
        end
      end
      DONE: begin
        if (cs_rise) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, MISO drive, receive result and event pulses.
  always_ff @(posedge sys_clk_in or posedge rst) begin
    if (rst) begin
      wide_q      <= 1'b0;
      bit_cnt     <= '0;
      pending     <= 1'b0;
      spi_miso_o  <= 1'b1;
      spi_miso_t  <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      frame_abort <= abort;
      rx_overrun  <= complete & rx_valid & ~rx_ack;
      tx_underrun <= start & ~load_have;

      if (start)        pending <= 1'b0;
      else if (tx_load) pending <= 1'b1;

      if (start) begin
        wide_q  <= spi_wide;
        bit_cnt <= spi_first_bit(spi_wide);
      end else if (shift_in) begin
        bit_cnt <= bit_cnt - 1'b1;
      end

      if (start) begin
        spi_miso_t <= 1'b0;
        spi_miso_o <= tx_init[31];
      end else if (advance) begin
        spi_miso_o <= tx_sh[30];
      end
      if (abort || finish) spi_miso_t <= 1'b1;

      if (complete) rx_data <= wide_q ? rx_next : {24'h0, rx_next[7:0]};

      if (complete)    rx_valid <= 1'b1;
      else if (rx_ack) rx_valid <= 1'b0;
    end
  end

  // Shift registers and tx holding buffer; their contents only matter while
  // the control state says they are valid.
  always_ff @(posedge sys_clk_in) begin
    if (tx_load) tx_buf <= tx_data;

    if (start)        tx_sh <= tx_init;
    else if (advance) tx_sh <= {tx_sh[30:0], tx_sh[31]};

    if (start)         rx_sh <= '0;
    else if (shift_in) rx_sh <= rx_next;
  end

`ifdef SPI_TARGET_ERR_CNT_EN
  logic err_evt;
  assign err_evt = frame_abort | rx_overrun | tx_underrun;

  // Saturating error-event counter; clear has priority over counting.
  always_ff @(posedge sys_clk_in or posedge rst) begin
    if (rst)                             err_cnt <= '0;
    else if (err_clr)                    err_cnt <= '0;
    else if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: table of complete frames plus hand-written
// abort, underrun/overrun, tx overwrite and mid-frame reset sequences.
module tb_spi_target;

  logic        clk;
  logic        rst;
  logic        sclk, cs_n, mosi;
  logic        miso_o, miso_t;
  logic        spi_wide;
  logic [31:0] tx_data;
  logic        tx_load;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic        busy;
  logic        frame_abort, rx_overrun, tx_underrun;
`ifdef SPI_TARGET_ERR_CNT_EN
  logic        err_clr;
  logic [7:0]  err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_abort  = 0;
  int n_ovr    = 0;
  int n_und    = 0;

  spi_target #(.SYNC_STAGES(2), .IDLE_FILL(32'hFFFF_FFFF)) dut (
    .sys_clk_in  (clk),
    .rst         (rst),
    .spi_clk_i   (sclk),
    .spi_cs_n_i  (cs_n),
    .spi_mosi_i  (mosi),
    .spi_miso_o  (miso_o),
    .spi_miso_t  (miso_t),
    .spi_wide    (spi_wide),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .busy        (busy),
    .frame_abort (frame_abort),
    .rx_overrun  (rx_overrun),
    .tx_underrun (tx_underrun)
`ifdef SPI_TARGET_ERR_CNT_EN
    ,
    .err_clr     (err_clr),
    .err_cnt     (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge; tests take deltas.
  always @(negedge clk) begin
    if (frame_abort) n_abort++;
    if (rx_overrun)  n_ovr++;
    if (tx_underrun) n_und++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_tx(input logic [31:0] w);
    @(negedge clk);
    tx_data = w;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic ack_rx();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  // Initiator model: SCLK phases of 4 sys_clk each; MISO sampled just
  // before each rising edge. Stops after nrise rises; raises CS if finish.
  task automatic spi_xfer(input logic wide, input logic [31:0] mosi_w, input int nrise,
                          input logic finish, output logic [31:0] miso_w);
    int nb;
    nb     = wide ? 32 : 8;
    miso_w = '0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nrise; i++) begin
      mosi = mosi_w[nb-1-i];
      repeat (4) @(negedge clk);
      miso_w = {miso_w[30:0], miso_o};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    if (finish) begin
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  typedef struct {
    logic        wide;
    logic        load;
    logic [31:0] tx;
    logic [31:0] mosi;
    logic [31:0] exp_miso;
    logic [31:0] exp_rx;
    int          exp_und;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] w;
  int          a0, o0, u0;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h0000_00A5, 32'h0000_003C, 32'h0000_00A5, 32'h0000_003C, 0};
    vecs[1] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 0};
    vecs[2] = '{1'b0, 1'b1, 32'h1234_5681, 32'h0000_00E7, 32'h0000_0081, 32'h0000_00E7, 0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0000, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 1};

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    spi_wide = 1'b0; tx_data = '0; tx_load = 1'b0; rx_ack = 1'b0;
`ifdef SPI_TARGET_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_miso_o", {31'h0, miso_o}, 32'h1);
    check("rst_miso_t", {31'h0, miso_t}, 32'h1);
    check("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
    check("rst_rx_data", rx_data, 32'h0);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_pulses", {29'h0, frame_abort, rx_overrun, tx_underrun}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", {31'h0, busy}, 32'h0);

    // Complete frames from the table.
    for (int v = 0; v < 4; v++) begin
      spi_wide = vecs[v].wide;
      if (vecs[v].load) load_tx(vecs[v].tx);
      check("tx_ready_pre", {31'h0, tx_ready}, {31'h0, ~vecs[v].load});
      a0 = n_abort; o0 = n_ovr; u0 = n_und;
      spi_xfer(vecs[v].wide, vecs[v].mosi, vecs[v].wide ? 32 : 8, 1'b1, w);
      check("vec_miso", w, vecs[v].exp_miso);
      check("vec_rx_data", rx_data, vecs[v].exp_rx);
      check("vec_rx_valid", {31'h0, rx_valid}, 32'h1);
      check("vec_tx_ready", {31'h0, tx_ready}, 32'h1);
      check("vec_underrun", n_und - u0, vecs[v].exp_und);
      check("vec_overrun", n_ovr - o0, 32'h0);
      check("vec_abort", n_abort - a0, 32'h0);
      check("vec_miso_t", {31'h0, miso_t}, 32'h1);
      check("vec_busy", {31'h0, busy}, 32'h0);
      ack_rx();
      check("vec_rx_valid_ack", {31'h0, rx_valid}, 32'h0);
    end

    // Abort: leave a result pending, then cut a frame after 5 rises.
    spi_wide = 1'b0;
    load_tx(32'h0000_0000);
    spi_xfer(1'b0, 32'h0000_0077, 8, 1'b1, w);
    load_tx(32'h0000_0055);
    a0 = n_abort; u0 = n_und;
    spi_xfer(1'b0, 32'h0000_00AA, 5, 1'b1, w);
    check("abort_pulse", n_abort - a0, 32'h1);
    check("abort_underrun", n_und - u0, 32'h0);
    check("abort_miso_bits", w, 32'h0000_000A);
    check("abort_rx_valid", {31'h0, rx_valid}, 32'h1);
    check("abort_rx_data", rx_data, 32'h0000_0077);
    check("abort_miso_t", {31'h0, miso_t}, 32'h1);
    check("abort_busy", {31'h0, busy}, 32'h0);
    ack_rx();

    // Underrun twice, overrun once on the second completion.
    u0 = n_und; o0 = n_ovr;
    spi_xfer(1'b0, 32'h0000_0011, 8, 1'b1, w);
    check("und1_miso", w, 32'h0000_00FF);
    spi_xfer(1'b0, 32'h0000_0022, 8, 1'b1, w);
    check("und2_miso", w, 32'h0000_00FF);
    check("und_pulses", n_und - u0, 32'h2);
    check("ovr_pulses", n_ovr - o0, 32'h1);
    check("ovr_rx_data", rx_data, 32'h0000_0022);
    check("ovr_rx_valid", {31'h0, rx_valid}, 32'h1);
    ack_rx();

    // Second tx_load overwrites the pending word.
    load_tx(32'h0000_0011);
    load_tx(32'h0000_0099);
    spi_xfer(1'b0, 32'h0000_0000, 8, 1'b1, w);
    check("overwrite_miso", w, 32'h0000_0099);

    // Reset in the middle of a frame (rx_valid still high from above).
    spi_xfer(1'b0, 32'h0000_00C3, 3, 1'b0, w);
    load_tx(32'h0000_003C);
    check("mid_busy", {31'h0, busy}, 32'h1);
    check("mid_miso_t", {31'h0, miso_t}, 32'h0);
    check("mid_tx_ready", {31'h0, tx_ready}, 32'h0);
    check("mid_rx_valid", {31'h0, rx_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mrst_miso_o", {31'h0, miso_o}, 32'h1);
    check("mrst_miso_t", {31'h0, miso_t}, 32'h1);
    check("mrst_tx_ready", {31'h0, tx_ready}, 32'h1);
    check("mrst_rx_data", rx_data, 32'h0);
    check("mrst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("mrst_busy", {31'h0, busy}, 32'h0);
    cs_n = 1'b1; sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    a0 = n_abort; u0 = n_und;
    load_tx(32'h0000_003C);
    spi_xfer(1'b0, 32'h0000_005A, 8, 1'b1, w);
    check("post_rst_miso", w, 32'h0000_003C);
    check("post_rst_rx_data", rx_data, 32'h0000_005A);
    check("post_rst_rx_valid", {31'h0, rx_valid}, 32'h1);
    check("post_rst_pulses", (n_abort - a0) + (n_und - u0), 32'h0);
    ack_rx();

`ifdef SPI_TARGET_ERR_CNT_EN
    // 300 aborted frames saturate the error counter; clear zeroes it.
    for (int k = 0; k < 300; k++) begin
      spi_xfer(1'b0, 32'h0000_0000, 1, 1'b1, w);
    end
    check("err_cnt_sat", {24'h0, err_cnt}, 32'd255);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cnt_clr", {24'h0, err_cnt}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
